// File: rtl/ppu_vec_unit_pkg.sv
// Shared definitions for the PPU vector unit: operator width, FSM states and
// the lane-count legality check.
package ppu_vec_unit_pkg;

    localparam int PPU_OP_WIDTH = 4;

    localparam logic [PPU_OP_WIDTH-1:0] PPU_OP_ADD = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } ppu_state_e;

    function automatic bit ppu_lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4);
    endfunction

endpackage

// File: rtl/ppu_lane_collect.sv
// Per-lane completion tracker: remembers the first result strobe of a lane
// and zeroes the slice if the operation is aborted before the lane finished.
module ppu_lane_collect #(
    parameter int LW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          cap_en_i,
    input  logic          abort_i,
    input  logic          strobe_i,
    input  logic [LW-1:0] res_i,
    output logic          done_o,
    output logic [LW-1:0] slice_o
);

    logic          done_q, done_d;
    logic [LW-1:0] slice_q, slice_d;

    always_comb begin
        done_d  = done_q;
        slice_d = slice_q;
        if (clr_i) begin
            done_d = 1'b0;
        end else if (cap_en_i && strobe_i && !done_q) begin
            done_d  = 1'b1;
            slice_d = res_i;
        end else if (abort_i && !done_q) begin
            // a strobe in the abort cycle still counts as finished
            slice_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q  <= 1'b0;
            slice_q <= '0;
        end else begin
            done_q  <= done_d;
            slice_q <= slice_d;
        end
    end

    assign done_o  = done_q;
    assign slice_o = slice_q;

endmodule

// File: rtl/ppu_vec_unit.sv
// PPU vector unit: latches a request, starts all lanes, collects per-lane
// results and holds the packed result until consumed.
// Optional watchdog abort in BUSY is enabled by macro PPU_VEC_TIMEOUT_EN.
module ppu_vec_unit
    import ppu_vec_unit_pkg::*;
#(
    parameter int LANES          = 2,
    parameter int OP_W           = PPU_OP_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  op_i,
    input  logic [31:0]      operand_a_i,
    input  logic [31:0]      operand_b_i,
    output logic [31:0]      result_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             lane_start_o,
    output logic [OP_W-1:0]  lane_op_o,
    output logic [31:0]      lane_op_a_o,
    output logic [31:0]      lane_op_b_o,
    input  logic [LANES-1:0] lane_valid_i,
    input  logic [31:0]      lane_result_i,
    output logic             err_o
);

    localparam int LW = 32 / LANES;

    if (!ppu_lanes_legal(LANES) || TIMEOUT_CYCLES < 1) begin : g_bad_config
        $error("ppu_vec_unit: LANES must be 1, 2 or 4 and TIMEOUT_CYCLES >= 1");
    end

    ppu_state_e            state_q, state_d;
    logic [OP_W-1:0]       lane_op_q, lane_op_d;
    logic [31:0]           op_a_q, op_a_d;
    logic [31:0]           op_b_q, op_b_d;
    logic [LANES-1:0]      done_mask;
    logic [LANES-1:0]      strobe_hit;
    logic [LANES-1:0][LW-1:0] slices;
    logic                  cap_en;
    logic                  all_done;
    logic                  clr;
    logic                  timeout;

    assign cap_en     = (state_q == ST_ISSUE) || (state_q == ST_BUSY);
    assign strobe_hit = lane_valid_i & {LANES{cap_en}};
    assign all_done   = &(done_mask | strobe_hit);
    assign clr        = (state_q == ST_DONE) && out_ready_i;

`ifdef PPU_VEC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout = (state_q == ST_BUSY) && !all_done &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_BUSY) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        err_d = err_q;
        if (timeout) begin
            err_d = 1'b1;
        end else if (clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        lane_op_d = lane_op_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_d   = ST_ISSUE;
                    lane_op_d = op_i;
                    op_a_d    = operand_a_i;
                    op_b_d    = operand_b_i;
                end
            end
            // ISSUE always passes through BUSY so completion takes >= 2 cycles
            ST_ISSUE: state_d = ST_BUSY;
            ST_BUSY: begin
                if (all_done || timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            lane_op_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
        end else begin
            state_q   <= state_d;
            lane_op_q <= lane_op_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ppu_lane_collect #(
            .LW(LW)
        ) u_collect (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (clr),
            .cap_en_i(cap_en),
            .abort_i (timeout),
            .strobe_i(lane_valid_i[k]),
            .res_i   (lane_result_i[k*LW +: LW]),
            .done_o  (done_mask[k]),
            .slice_o (slices[k])
        );
    end

    assign result_o     = slices;
    assign in_ready_o   = (state_q == ST_IDLE);
    assign lane_start_o = (state_q == ST_ISSUE);
    assign out_valid_o  = (state_q == ST_DONE);
    assign lane_op_o    = lane_op_q;
    assign lane_op_a_o  = op_a_q;
    assign lane_op_b_o  = op_b_q;

endmodule

// File: tb/tb_ppu_vec_unit.sv
// Bench for ppu_vec_unit: a LANES=2 and a LANES=4 instance driven by directed
// vectors, checked every cycle against a transaction-level model.
module tb_ppu_vec_unit;

    logic             clk;
    logic [1:0]       rst;
    logic [1:0]       in_valid;
    logic [1:0][3:0]  op;
    logic [1:0][31:0] a;
    logic [1:0][31:0] b;
    logic [1:0]       out_ready;
    logic [1:0][3:0]  lv;
    logic [1:0][31:0] lres;

    logic [1:0]       in_ready;
    logic [1:0]       out_valid;
    logic [1:0]       lane_start;
    logic [1:0]       err;
    logic [1:0][3:0]  lop;
    logic [1:0][31:0] lopa;
    logic [1:0][31:0] lopb;
    logic [1:0][31:0] res;

    int n_checks;
    int n_fails;
    bit cmp_on;

    // model state per instance (0 idle, 1 issue, 2 waiting, 3 result held)
    int          m_ph  [2];
    int          m_cnt [2];
    logic [3:0]  m_got [2];
    logic [31:0] m_res [2];
    logic [3:0]  m_op  [2];
    logic [31:0] m_a   [2];
    logic [31:0] m_b   [2];
    logic        m_err [2];

    ppu_vec_unit #(.LANES(2), .OP_W(4), .TIMEOUT_CYCLES(8)) u_dut2 (
        .clk_i(clk), .rst_i(rst[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .op_i(op[0]), .operand_a_i(a[0]), .operand_b_i(b[0]), .result_o(res[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .lane_start_o(lane_start[0]),
        .lane_op_o(lop[0]), .lane_op_a_o(lopa[0]), .lane_op_b_o(lopb[0]),
        .lane_valid_i(lv[0][1:0]), .lane_result_i(lres[0]), .err_o(err[0])
    );

    ppu_vec_unit #(.LANES(4), .OP_W(4), .TIMEOUT_CYCLES(8)) u_dut4 (
        .clk_i(clk), .rst_i(rst[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .op_i(op[1]), .operand_a_i(a[1]), .operand_b_i(b[1]), .result_o(res[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .lane_start_o(lane_start[1]),
        .lane_op_o(lop[1]), .lane_op_a_o(lopa[1]), .lane_op_b_o(lopb[1]),
        .lane_valid_i(lv[1]), .lane_result_i(lres[1]), .err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input int i);
        int ln;
        int lw;
        logic [31:0] mask;
        logic [31:0] full;
        ln   = (i == 0) ? 2 : 4;
        lw   = 32 / ln;
        mask = (32'd1 << lw) - 32'd1;
        full = (32'd1 << ln) - 32'd1;
        if (rst[i]) begin
            m_ph[i] = 0; m_cnt[i] = 0; m_got[i] = 4'd0; m_res[i] = 32'd0;
            m_op[i] = 4'd0; m_a[i] = 32'd0; m_b[i] = 32'd0; m_err[i] = 1'b0;
        end else begin
            case (m_ph[i])
                0: if (in_valid[i]) begin
                    m_op[i] = op[i]; m_a[i] = a[i]; m_b[i] = b[i];
                    m_ph[i] = 1; m_cnt[i] = 0;
                end
                1, 2: begin
                    for (int k = 0; k < ln; k++) begin
                        if (lv[i][k] && !m_got[i][k]) begin
                            m_got[i][k] = 1'b1;
                            m_res[i] = (m_res[i] & ~(mask << (k*lw))) | (lres[i] & (mask << (k*lw)));
                        end
                    end
                    if (m_ph[i] == 1) m_ph[i] = 2;
                    else if ({28'd0, m_got[i]} == full) m_ph[i] = 3;
`ifdef PPU_VEC_TIMEOUT_EN
                    else begin
                        m_cnt[i]++;
                        if (m_cnt[i] == 8) begin
                            m_ph[i] = 3;
                            m_err[i] = 1'b1;
                            for (int k = 0; k < ln; k++)
                                if (!m_got[i][k]) m_res[i] = m_res[i] & ~(mask << (k*lw));
                        end
                    end
`endif
                end
                default: if (out_ready[i]) begin
                    m_got[i] = 4'd0; m_ph[i] = 0; m_err[i] = 1'b0;
                end
            endcase
        end
    endtask

    task automatic compare(input int i);
        string p;
        p = (i == 0) ? "l2" : "l4";
        chk({p, "_in_ready"},   {31'd0, in_ready[i]},   {31'd0, m_ph[i] == 0});
        chk({p, "_out_valid"},  {31'd0, out_valid[i]},  {31'd0, m_ph[i] == 3});
        chk({p, "_lane_start"}, {31'd0, lane_start[i]}, {31'd0, m_ph[i] == 1});
        chk({p, "_err"},        {31'd0, err[i]},        {31'd0, m_err[i]});
        chk({p, "_result"},     res[i],                 m_res[i]);
        chk({p, "_lane_op"},    {28'd0, lop[i]},        {28'd0, m_op[i]});
        chk({p, "_lane_op_a"},  lopa[i],                m_a[i]);
        chk({p, "_lane_op_b"},  lopb[i],                m_b[i]);
    endtask

    task automatic accept(input int i, input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb);
        op[i] = o; a[i] = va; b[i] = vb; in_valid[i] = 1'b1;
        tick();
        in_valid[i] = 1'b0;
    endtask

    task automatic release_result(input int i);
        out_ready[i] = 1'b1;
        tick();
        out_ready[i] = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fails = 0; cmp_on = 1'b0;
        rst = 2'b11; in_valid = '0; op = '0; a = '0; b = '0;
        out_ready = '0; lv = '0; lres = '0;
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_cnt[i] = 0; m_got[i] = 4'd0; m_res[i] = 32'd0;
            m_op[i] = 4'd0; m_a[i] = 32'd0; m_b[i] = 32'd0; m_err[i] = 1'b0;
        end
        fork
            forever begin
                @(posedge clk);
                for (int i = 0; i < 2; i++) model_step(i);
            end
            forever begin
                @(negedge clk);
                if (cmp_on) for (int i = 0; i < 2; i++) compare(i);
            end
        join_none

        tick(); tick();
        rst = 2'b00;
        cmp_on = 1'b1;
        chk("rst_in_ready", {30'd0, in_ready}, 32'd3);
        chk("rst_out_valid", {30'd0, out_valid}, 32'd0);
        chk("rst_result4", res[1], 32'd0);

        // two lanes, add, both strobe in the cycle after the start pulse
        accept(0, 4'h0, 32'h40004000, 32'h40004000);
        chk("a_lane_start", {31'd0, lane_start[0]}, 32'd1);
        chk("a_lane_op_a", lopa[0], 32'h40004000);
        tick();
        chk("a_valid_1cyc", {31'd0, out_valid[0]}, 32'd0);
        lv[0] = 4'b0011; lres[0] = 32'h48004800;
        tick();
        lv[0] = 4'b0000;
        chk("a_valid_2cyc", {31'd0, out_valid[0]}, 32'd1);
        chk("a_result", res[0], 32'h48004800);
        chk("a_err", {31'd0, err[0]}, 32'd0);
        release_result(0);
        chk("a_idle", {31'd0, in_ready[0]}, 32'd1);

        // four lanes strobing 3,1,0,2; lane 3 re-strobes with a different value
        accept(1, 4'h1, 32'h01020304, 32'h05060708);
        tick();
        lv[1] = 4'b1000; lres[1] = 32'h44000000; tick();
        chk("b_wait_l3", {31'd0, out_valid[1]}, 32'd0);
        lv[1] = 4'b1010; lres[1] = 32'h99002200; tick();
        chk("b_wait_l1", {31'd0, out_valid[1]}, 32'd0);
        lv[1] = 4'b0001; lres[1] = 32'h00000011; tick();
        chk("b_wait_l0", {31'd0, out_valid[1]}, 32'd0);
        lv[1] = 4'b0100; lres[1] = 32'h00330000; tick();
        lv[1] = 4'b0000;
        chk("b_done", {31'd0, out_valid[1]}, 32'd1);
        chk("b_result", res[1], 32'h44332211);

        // backpressure with new requests and spurious strobes in DONE
        for (int c = 0; c < 5; c++) begin
            out_ready[1] = 1'b0; in_valid[1] = 1'b1; a[1] = 32'hDEADBEEF;
            lv[1] = 4'b1111; lres[1] = 32'hFFFFFFFF;
            tick();
            chk("bp_result", res[1], 32'h44332211);
            chk("bp_in_ready", {31'd0, in_ready[1]}, 32'd0);
        end
        lv[1] = 4'b0000;
        release_result(1);
        chk("bp_idle", {31'd0, in_ready[1]}, 32'd1);
        chk("bp_no_accept", {31'd0, lane_start[1]}, 32'd0);
        chk("bp_op_a_kept", lopa[1], 32'h01020304);
        tick();
        in_valid[1] = 1'b0;
        chk("bp_next_start", {31'd0, lane_start[1]}, 32'd1);
        chk("bp_next_op_a", lopa[1], 32'hDEADBEEF);
        lv[1] = 4'b1111; lres[1] = 32'h0A0B0C0D; tick();
        lv[1] = 4'b0000; tick();
        chk("bp_next_result", res[1], 32'h0A0B0C0D);
        release_result(1);

        // reset in BUSY with lane 0 already captured
        accept(0, 4'h2, 32'h11112222, 32'h33334444);
        tick();
        lv[0] = 4'b0001; lres[0] = 32'h0000BEEF; tick();
        lv[0] = 4'b0000; rst[0] = 1'b1; tick();
        rst[0] = 1'b0;
        chk("r_in_ready", {31'd0, in_ready[0]}, 32'd1);
        chk("r_out_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("r_result", res[0], 32'd0);
        accept(0, 4'h3, 32'h55556666, 32'h77778888);
        tick();
        lv[0] = 4'b0010; lres[0] = 32'h12340000; tick();
        chk("r_no_stale", {31'd0, out_valid[0]}, 32'd0);
        lv[0] = 4'b0001; lres[0] = 32'h00005678; tick();
        lv[0] = 4'b0000; tick();
        chk("r_done", {31'd0, out_valid[0]}, 32'd1);
        chk("r_result_new", res[0], 32'h12345678);
        release_result(0);

        // lane 1 never strobes
        accept(0, 4'h0, 32'h0000ABCD, 32'h0);
        tick();
        lv[0] = 4'b0001; lres[0] = 32'h0000ABCD; tick();
        lv[0] = 4'b0000;
`ifdef PPU_VEC_TIMEOUT_EN
        for (int c = 0; c < 20 && !out_valid[0]; c++) tick();
        chk("t_done", {31'd0, out_valid[0]}, 32'd1);
        chk("t_err", {31'd0, err[0]}, 32'd1);
        chk("t_result", res[0], 32'h0000ABCD);
        release_result(0);
        chk("t_err_clr", {31'd0, err[0]}, 32'd0);
`else
        for (int c = 0; c < 100; c++) tick();
        chk("t_still_busy", {31'd0, out_valid[0]}, 32'd0);
        chk("t_no_ready", {31'd0, in_ready[0]}, 32'd0);
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        chk("t_recover", {31'd0, in_ready[0]}, 32'd1);
`endif
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
